// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the IF and MEM stages.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both stages request at once.
module mem_port_arbiter #(
  parameter int NBits       = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [NBits-1:0] if_addr,
  output logic             if_ack,
  output logic [NBits-1:0] if_rdata,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [NBits-1:0] mem_addr,
  input  logic [NBits-1:0] mem_wdata,
  output logic             mem_ack,
  output logic [NBits-1:0] mem_rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [NBits-1:0] ram_addr,
  output logic [NBits-1:0] ram_wdata,
  input  logic [NBits-1:0] ram_rdata,
  output logic             stall_if,
  output logic             stall_mem
);

  localparam int CntW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    Idle,
    Issue,
    Wait,
    Resp
  } state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic            grantMem;
  logic            pickMem;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrantMem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrantMem <= 1'b0;
    end else if (state == Issue) begin
      lastGrantMem <= grantMem;
    end
  end

  // Contention goes to whichever stage was not served last.
  assign pickMem = mem_req & ~(if_req & lastGrantMem);
`else
  // The older instruction (MEM) always wins, so the pipeline drains.
  assign pickMem = mem_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= Idle;
      cnt       <= '0;
      grantMem  <= 1'b0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en  <= 1'b0;
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      unique case (state)
        Idle: begin
          if (if_req | mem_req) begin
            grantMem <= pickMem;
            ram_addr <= pickMem ? mem_addr : if_addr;
            ram_we   <= pickMem & mem_we;
            if (pickMem) begin
              ram_wdata <= mem_wdata;
            end
            ram_en <= 1'b1;
            state  <= Issue;
          end
        end
        Issue: begin
          cnt   <= CntW'(MEM_LATENCY);
          state <= Wait;
        end
        Wait: begin
          cnt <= cnt - 1'b1;
          if (cnt == CntW'(1)) begin
            // Stores travel the same path but leave rdata untouched.
            if (!ram_we) begin
              if (grantMem) begin
                mem_rdata <= ram_rdata;
              end else begin
                if_rdata <= ram_rdata;
              end
            end
            if_ack  <= ~grantMem;
            mem_ack <= grantMem;
            state   <= Resp;
          end
        end
        Resp: begin
          state <= Idle;
        end
      endcase
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule
